// File: rtl/alu_arbiter_if.sv
// Bundle of requester, ALU-control and response signals for alu_arbiter.
// slave: the arbiter; master: requesters plus the ALU/bus environment.
interface alu_arbiter_if #(
  parameter int WIDTH = 32
);
  logic             req0_valid;
  logic             req0_ready;
  logic [WIDTH-1:0] req0_a;
  logic [WIDTH-1:0] req0_b;
  logic [2:0]       req0_op;
  logic             req0_sub;
  logic             req0_sra;
  logic             req0_addr;
  logic             req0_lock;

  logic             req1_valid;
  logic             req1_ready;
  logic [WIDTH-1:0] req1_a;
  logic [WIDTH-1:0] req1_b;
  logic [2:0]       req1_op;
  logic             req1_sub;
  logic             req1_sra;
  logic             req1_addr;
  logic             req1_lock;

  logic [WIDTH-1:0] alu_a;
  logic [WIDTH-1:0] alu_b;
  logic [2:0]       alu_op;
  logic             alu_sub_en;
  logic             alu_sra_en;
  logic             alu_bus_en;
  logic             alu_addr_en;
  logic [WIDTH-1:0] alu_result;
  logic             alu_eq;
  logic             alu_lt;
  logic             alu_ltu;

  logic             rsp_valid;
  logic             rsp_id;
  logic [WIDTH-1:0] rsp_data;
  logic             rsp_eq;
  logic             rsp_lt;
  logic             rsp_ltu;

  modport slave (
    input  req0_valid, req0_a, req0_b, req0_op, req0_sub, req0_sra, req0_addr, req0_lock,
    output req0_ready,
    input  req1_valid, req1_a, req1_b, req1_op, req1_sub, req1_sra, req1_addr, req1_lock,
    output req1_ready,
    output alu_a, alu_b, alu_op, alu_sub_en, alu_sra_en, alu_bus_en, alu_addr_en,
    input  alu_result, alu_eq, alu_lt, alu_ltu,
    output rsp_valid, rsp_id, rsp_data, rsp_eq, rsp_lt, rsp_ltu
  );

  modport master (
    output req0_valid, req0_a, req0_b, req0_op, req0_sub, req0_sra, req0_addr, req0_lock,
    input  req0_ready,
    output req1_valid, req1_a, req1_b, req1_op, req1_sub, req1_sra, req1_addr, req1_lock,
    input  req1_ready,
    input  alu_a, alu_b, alu_op, alu_sub_en, alu_sra_en, alu_bus_en, alu_addr_en,
    output alu_result, alu_eq, alu_lt, alu_ltu,
    input  rsp_valid, rsp_id, rsp_data, rsp_eq, rsp_lt, rsp_ltu
  );
endinterface

// File: rtl/alu_arbiter.sv
// Round-robin arbiter sharing one combinational ALU between the execute stage
// (port 0) and address generation (port 1). Optional short lock keeps the
// grant with one port for up to MAX_LOCK consecutive operations.
// Pipeline: accept -> EXEC (ALU driven) -> response, one op per cycle.
module alu_arbiter #(
  parameter int WIDTH    = 32,
  parameter int MAX_LOCK = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  alu_arbiter_if.slave  bus
);

  localparam int CW = $clog2(MAX_LOCK + 1);

  // Arbitration state
  logic          last_grant;
  logic          lock_q;
  logic          lock_owner;
  logic [CW-1:0] lock_cnt;

  // EXEC stage registers
  logic             exec_valid;
  logic             exec_id;
  logic [WIDTH-1:0] exec_a;
  logic [WIDTH-1:0] exec_b;
  logic [2:0]       exec_op;
  logic             exec_sub;
  logic             exec_sra;
  logic             exec_addr;

  // Response registers
  logic             rsp_valid_q;
  logic             rsp_id_q;
  logic [WIDTH-1:0] rsp_data_q;
  logic             rsp_eq_q;
  logic             rsp_lt_q;
  logic             rsp_ltu_q;

  logic          owner_valid;
  logic          lock_eff;
  logic          rdy0;
  logic          rdy1;
  logic          acc0;
  logic          acc1;
  logic          acc;
  logic          sel;
  logic          sel_lock;
  logic [CW-1:0] inc_cnt;

  // A lock only holds while its owner keeps requesting; an idle owner
  // releases it in that same cycle so the other port can be served.
  assign owner_valid = lock_owner ? bus.req1_valid : bus.req0_valid;
  assign lock_eff    = lock_q & owner_valid;

  // Grant selection: lock owner first, else round-robin on ties
  always_comb begin
    rdy0 = 1'b0;
    rdy1 = 1'b0;
    if (rst_n) begin
      if (lock_eff) begin
        rdy0 = ~lock_owner;
        rdy1 = lock_owner;
      end else if (bus.req0_valid && bus.req1_valid) begin
        rdy0 = last_grant;
        rdy1 = ~last_grant;
      end else begin
        rdy0 = bus.req0_valid;
        rdy1 = bus.req1_valid;
      end
    end
  end

  assign bus.req0_ready = rdy0;
  assign bus.req1_ready = rdy1;

  assign acc0     = bus.req0_valid & rdy0;
  assign acc1     = bus.req1_valid & rdy1;
  assign acc      = acc0 | acc1;
  assign sel      = acc1;
  assign sel_lock = sel ? bus.req1_lock : bus.req0_lock;
  assign inc_cnt  = lock_eff ? lock_cnt + CW'(1) : CW'(1);

  // Round-robin pointer and lock bookkeeping
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      last_grant <= 1'b1;
      lock_q     <= 1'b0;
      lock_owner <= 1'b0;
      lock_cnt   <= '0;
    end else if (acc) begin
      last_grant <= sel;
      if (sel_lock && (inc_cnt < CW'(MAX_LOCK))) begin
        lock_q     <= 1'b1;
        lock_owner <= sel;
        lock_cnt   <= inc_cnt;
      end else begin
        lock_q   <= 1'b0;
        lock_cnt <= '0;
      end
    end else if (!lock_eff) begin
      lock_q   <= 1'b0;
      lock_cnt <= '0;
    end
  end

  // Register the granted operation for the EXEC cycle; operands hold when idle
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      exec_valid <= 1'b0;
      exec_id    <= 1'b0;
      exec_a     <= '0;
      exec_b     <= '0;
      exec_op    <= '0;
      exec_sub   <= 1'b0;
      exec_sra   <= 1'b0;
      exec_addr  <= 1'b0;
    end else begin
      exec_valid <= acc;
      if (acc) begin
        exec_id   <= sel;
        exec_a    <= sel ? bus.req1_a    : bus.req0_a;
        exec_b    <= sel ? bus.req1_b    : bus.req0_b;
        exec_op   <= sel ? bus.req1_op   : bus.req0_op;
        exec_sub  <= sel ? bus.req1_sub  : bus.req0_sub;
        exec_sra  <= sel ? bus.req1_sra  : bus.req0_sra;
        exec_addr <= sel ? bus.req1_addr : bus.req0_addr;
      end
    end
  end

  assign bus.alu_a       = exec_a;
  assign bus.alu_b       = exec_b;
  assign bus.alu_op      = exec_op;
  assign bus.alu_sub_en  = exec_sub;
  assign bus.alu_sra_en  = exec_sra;
  assign bus.alu_bus_en  = exec_valid & ~exec_addr;
  assign bus.alu_addr_en = exec_valid & exec_addr;

  // Capture ALU result and flags at the end of EXEC; hold between responses
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rsp_valid_q <= 1'b0;
      rsp_id_q    <= 1'b0;
      rsp_data_q  <= '0;
      rsp_eq_q    <= 1'b0;
      rsp_lt_q    <= 1'b0;
      rsp_ltu_q   <= 1'b0;
    end else begin
      rsp_valid_q <= exec_valid;
      if (exec_valid) begin
        rsp_id_q   <= exec_id;
        rsp_data_q <= bus.alu_result;
        rsp_eq_q   <= bus.alu_eq;
        rsp_lt_q   <= bus.alu_lt;
        rsp_ltu_q  <= bus.alu_ltu;
      end
    end
  end

  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_id    = rsp_id_q;
  assign bus.rsp_data  = rsp_data_q;
  assign bus.rsp_eq    = rsp_eq_q;
  assign bus.rsp_lt    = rsp_lt_q;
  assign bus.rsp_ltu   = rsp_ltu_q;

endmodule
